// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
// Posted-write buffer between the core's load/store unit and a valid/ack
// data bus. Stores are queued in a FIFO and drained one bus transfer at a
// time. Loads take the bus with priority from IDLE. A load whose word
// address matches a queued store waits for the FIFO to drain.
//
// Optional build macro: STORE_FWD_EN
//   When defined, a hazarded load whose youngest matching store has a full
//   byte mask is answered from the FIFO in one cycle, with no bus access.
//
// Ports
//   clk_in, rst_in            clock, synchronous active-low reset
//   core_wr_req_in            store request (addr/wdata/wmask)
//   core_rd_req_in            load request, held with addr while stalled
//   core_addr_in              load/store byte address
//   core_wdata_in/wmask_in    lane-aligned store data and byte enables
//   core_rdata_out/rvalid_out load data and its one-cycle valid pulse
//   stall_out                 core must hold its current request
//   buf_empty_out             FIFO empty and bus idle
//   bus_*                     valid/ack bus master (req/we/addr/wdata/wmask, ack/rdata)
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        core_wr_req_in,
  input  logic [31:0] core_addr_in,
  input  logic [31:0] core_wdata_in,
  input  logic [3:0]  core_wmask_in,
  input  logic        core_rd_req_in,
  output logic [31:0] core_rdata_out,
  output logic        core_rvalid_out,
  output logic        stall_out,
  output logic        buf_empty_out,
  output logic        bus_req_out,
  output logic        bus_we_out,
  output logic [31:0] bus_addr_out,
  output logic [31:0] bus_wdata_out,
  output logic [3:0]  bus_wmask_out,
  input  logic        bus_ack_in,
  input  logic [31:0] bus_rdata_in
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  // FIFO storage: word address, data, byte mask
  logic [29:0] addr_mem [DEPTH];
  logic [31:0] data_mem [DEPTH];
  logic [3:0]  mask_mem [DEPTH];

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic [31:0] word_addr;
  logic        full, push, pop, rd_pending, any_match, hazard;
  logic [PTR_W-1:0] scan_idx;
`ifdef STORE_FWD_EN
  logic        fwd_hit;
  logic [31:0] fwd_data;
`endif

  assign word_addr  = core_addr_in & ~32'h3;
  assign full       = (count_q == FULL_CNT);
  assign push       = core_wr_req_in & ~full;
  assign pop        = (state_q == S_WRITE) & bus_ack_in;
  // During the rvalid pulse the held request is the one being answered.
  assign rd_pending = core_rd_req_in & ~rvalid_q;

  // Scan valid entries oldest to youngest; the last hit is the youngest.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    any_match = 1'b0;
    scan_idx  = '0;
`ifdef STORE_FWD_EN
    fwd_hit   = 1'b0;
    fwd_data  = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_mem[scan_idx] == word_addr[31:2])) begin
        any_match = 1'b1;
`ifdef STORE_FWD_EN
        fwd_hit   = (mask_mem[scan_idx] == 4'b1111);
        fwd_data  = data_mem[scan_idx];
`endif
      end
    end
  end

  // A store entering this cycle shares core_addr_in, so it always conflicts.
  assign hazard = any_match | push;

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_pending && !hazard)  state_d = S_READ;
        else if (count_q != '0)     state_d = S_WRITE;
      end
      S_WRITE: if (bus_ack_in) state_d = S_IDLE;
      S_READ: begin
        if (bus_ack_in) begin
          rdata_d  = bus_rdata_in;
          rvalid_d = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef STORE_FWD_EN
    // Full-word hit on the youngest matching store: answer from the FIFO.
    if (rd_pending && fwd_hit && !push && (state_q != S_READ)) begin
      rdata_d  = fwd_data;
      rvalid_d = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: FIFO storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk_in) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= word_addr[31:2];
      data_mem[wr_ptr_q] <= core_wdata_in;
      mask_mem[wr_ptr_q] <= core_wmask_in;
    end
  end

  assign core_rdata_out  = rdata_q;
  assign core_rvalid_out = rvalid_q;
  assign stall_out       = (core_wr_req_in & full) | (core_rd_req_in & ~rvalid_q);
  assign buf_empty_out   = (count_q == '0) & (state_q == S_IDLE);

  always_comb begin
    bus_req_out   = 1'b0;
    bus_we_out    = 1'b0;
    bus_addr_out  = '0;
    bus_wdata_out = '0;
    bus_wmask_out = '0;
    case (state_q)
      S_WRITE: begin
        bus_req_out   = 1'b1;
        bus_we_out    = 1'b1;
        bus_addr_out  = {addr_mem[rd_ptr_q], 2'b00};
        bus_wdata_out = data_mem[rd_ptr_q];
        bus_wmask_out = mask_mem[rd_ptr_q];
      end
      S_READ: begin
        bus_req_out  = 1'b1;
        bus_addr_out = word_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Testbench for dmem_store_buffer (default build, STORE_FWD_EN undefined).
// A cycle table covers reset, non-hazarded load priority, hazarded load
// drain and back-to-back load requests; hand sequences cover reset during
// a bus write, FIFO full/stall and pointer wrap-around.
module tb_dmem_store_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        core_wr_req_in, core_rd_req_in;
  logic [31:0] core_addr_in, core_wdata_in;
  logic [3:0]  core_wmask_in;
  logic [31:0] core_rdata_out;
  logic        core_rvalid_out, stall_out, buf_empty_out;
  logic        bus_req_out, bus_we_out;
  logic [31:0] bus_addr_out, bus_wdata_out;
  logic [3:0]  bus_wmask_out;
  logic        bus_ack_in;
  logic [31:0] bus_rdata_in;

  dmem_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .core_wr_req_in(core_wr_req_in), .core_addr_in(core_addr_in),
    .core_wdata_in(core_wdata_in), .core_wmask_in(core_wmask_in),
    .core_rd_req_in(core_rd_req_in), .core_rdata_out(core_rdata_out),
    .core_rvalid_out(core_rvalid_out), .stall_out(stall_out),
    .buf_empty_out(buf_empty_out), .bus_req_out(bus_req_out),
    .bus_we_out(bus_we_out), .bus_addr_out(bus_addr_out),
    .bus_wdata_out(bus_wdata_out), .bus_wmask_out(bus_wmask_out),
    .bus_ack_in(bus_ack_in), .bus_rdata_in(bus_rdata_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, wr, rd;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_baddr, e_bwdata;
    logic [3:0]  e_bmask;
    logic        e_rvalid;
    logic [31:0] e_crdata;
    logic        e_empty;
  } vec_t;

  vec_t        vecs [19];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] wq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, wr, rd, input logic [31:0] addr, wdata,
                              input logic [3:0] wmask, input logic ack, input logic [31:0] rdata,
                              input logic s, rq, we, input logic [31:0] ba, bw,
                              input logic [3:0] bm, input logic rv, input logic [31:0] cr,
                              input logic em);
    vec_t v;
    v.rst = rst; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.wmask = wmask;
    v.ack = ack; v.rdata = rdata; v.e_stall = s; v.e_req = rq; v.e_we = we;
    v.e_baddr = ba; v.e_bwdata = bw; v.e_bmask = bm; v.e_rvalid = rv;
    v.e_crdata = cr; v.e_empty = em;
    return v;
  endfunction

  task automatic set_in(input logic rst, wr, rd, input logic [31:0] addr, wdata,
                        input logic [3:0] wmask, input logic ack, input logic [31:0] rdata);
    rst_in = rst; core_wr_req_in = wr; core_rd_req_in = rd; core_addr_in = addr;
    core_wdata_in = wdata; core_wmask_in = wmask; bus_ack_in = ack; bus_rdata_in = rdata;
  endtask

  // Record every completed bus write in order.
  task automatic log_bus();
    if (bus_req_out && bus_we_out && bus_ack_in) wq.push_back(bus_addr_out);
  endtask

  // Idle core, ack every write immediately, until the buffer reports empty.
  task automatic drain(input string tag, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget; c++) begin
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      #1 bus_ack_in = bus_req_out & bus_we_out;
      #1 log_bus();
      done = buf_empty_out;
      @(negedge clk_in);
      if (done) break;
    end
    check({tag, " drain reached empty"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_order(input string tag, input int n, input logic [31:0] base);
    check({tag, " write count"}, wq.size(), n);
    for (int k = 0; k < n && k < wq.size(); k++)
      check($sformatf("%s write %0d addr", tag, k), wq[k], base + 32'(4 * k));
  endtask

  initial begin
    int          cnt;
    int          idx;
    logic        exp_stall;

    //            rst wr rd addr    wdata          mk ack rdata        | st rq we baddr  bwdata        bm rv crdata        em
    vecs[0]  = mk(0, 0, 0, 32'h0,   32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1);
    vecs[1]  = mk(1, 1, 0, 32'h200, 32'h11112222, 15, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        1);
    vecs[2]  = mk(1, 0, 1, 32'h300, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h0,        0);
    vecs[3]  = mk(1, 0, 1, 32'h300, 32'h0,         0, 0, 32'h0,         1, 1, 0, 32'h300, 32'h0,        0, 0, 32'h0,        0);
    vecs[4]  = mk(1, 0, 1, 32'h300, 32'h0,         0, 1, 32'hDEADBEEF,  1, 1, 0, 32'h300, 32'h0,        0, 0, 32'h0,        0);
    vecs[5]  = mk(1, 0, 0, 32'h0,   32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 1, 32'hDEADBEEF, 0);
    vecs[6]  = mk(1, 0, 0, 32'h0,   32'h0,         0, 0, 32'h0,         0, 1, 1, 32'h200, 32'h11112222, 15, 0, 32'hDEADBEEF, 0);
    vecs[7]  = mk(1, 0, 0, 32'h0,   32'h0,         0, 1, 32'h0,         0, 1, 1, 32'h200, 32'h11112222, 15, 0, 32'hDEADBEEF, 0);
    vecs[8]  = mk(1, 0, 0, 32'h0,   32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 1);
    vecs[9]  = mk(1, 1, 0, 32'h400, 32'hA5A5A5A5, 15, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 1);
    vecs[10] = mk(1, 0, 1, 32'h400, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 0);
    vecs[11] = mk(1, 0, 1, 32'h400, 32'h0,         0, 0, 32'h0,         1, 1, 1, 32'h400, 32'hA5A5A5A5, 15, 0, 32'hDEADBEEF, 0);
    vecs[12] = mk(1, 0, 1, 32'h400, 32'h0,         0, 1, 32'h0,         1, 1, 1, 32'h400, 32'hA5A5A5A5, 15, 0, 32'hDEADBEEF, 0);
    vecs[13] = mk(1, 0, 1, 32'h400, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h0,   32'h0,        0, 0, 32'hDEADBEEF, 1);
    vecs[14] = mk(1, 0, 1, 32'h400, 32'h0,         0, 1, 32'h12345678,  1, 1, 0, 32'h400, 32'h0,        0, 0, 32'hDEADBEEF, 0);
    vecs[15] = mk(1, 0, 1, 32'h400, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 1, 32'h12345678, 1);
    vecs[16] = mk(1, 0, 1, 32'h400, 32'h0,         0, 0, 32'h0,         1, 0, 0, 32'h0,   32'h0,        0, 0, 32'h12345678, 1);
    vecs[17] = mk(1, 0, 1, 32'h400, 32'h0,         0, 1, 32'hCAFEF00D,  1, 1, 0, 32'h400, 32'h0,        0, 0, 32'h12345678, 0);
    vecs[18] = mk(1, 0, 0, 32'h0,   32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,        0, 1, 32'hCAFEF00D, 1);

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);

    // Cycle table: reset, load priority over a queued store, hazarded load.
    for (int r = 0; r < 19; r++) begin
      set_in(vecs[r].rst, vecs[r].wr, vecs[r].rd, vecs[r].addr, vecs[r].wdata,
             vecs[r].wmask, vecs[r].ack, vecs[r].rdata);
      #2 log_bus();
      check($sformatf("row%0d stall", r),   {31'd0, stall_out},       {31'd0, vecs[r].e_stall});
      check($sformatf("row%0d bus_req", r), {31'd0, bus_req_out},     {31'd0, vecs[r].e_req});
      check($sformatf("row%0d bus_we", r),  {31'd0, bus_we_out},      {31'd0, vecs[r].e_we});
      check($sformatf("row%0d bus_addr", r), bus_addr_out,            vecs[r].e_baddr);
      check($sformatf("row%0d bus_wdata", r), bus_wdata_out,          vecs[r].e_bwdata);
      check($sformatf("row%0d bus_wmask", r), {28'd0, bus_wmask_out}, {28'd0, vecs[r].e_bmask});
      check($sformatf("row%0d rvalid", r),  {31'd0, core_rvalid_out}, {31'd0, vecs[r].e_rvalid});
      check($sformatf("row%0d rdata", r),   core_rdata_out,           vecs[r].e_crdata);
      check($sformatf("row%0d empty", r),   {31'd0, buf_empty_out},   {31'd0, vecs[r].e_empty});
      @(negedge clk_in);
    end

    // Reset while a write is on the bus; a following load goes straight out.
    set_in(1, 1, 0, 32'h10, 32'h1, 15, 0, 0);
    #2 @(negedge clk_in);
    set_in(1, 1, 0, 32'h14, 32'h2, 15, 0, 0);
    #2 @(negedge clk_in);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2 check("rst mid-write bus_req before", {31'd0, bus_req_out}, 32'd1);
    @(negedge clk_in);
    set_in(1, 0, 1, 32'h500, 0, 0, 0, 0);
    #2 check("rst mid-write bus_req after", {31'd0, bus_req_out}, 32'd0);
    check("rst mid-write empty", {31'd0, buf_empty_out}, 32'd1);
    check("rst mid-write rdata cleared", core_rdata_out, 32'h0);
    @(negedge clk_in);
    set_in(1, 0, 1, 32'h500, 0, 0, 1, 32'h55AA55AA);
    #2 check("rst load bus_req", {31'd0, bus_req_out}, 32'd1);
    check("rst load bus_we", {31'd0, bus_we_out}, 32'd0);
    check("rst load bus_addr", bus_addr_out, 32'h500);
    @(negedge clk_in);
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #2 check("rst load rvalid", {31'd0, core_rvalid_out}, 32'd1);
    check("rst load rdata", core_rdata_out, 32'h55AA55AA);
    @(negedge clk_in);

    // Fill to full: fifth store stalls, and the pop in its cycle does not
    // unblock it; it is accepted the cycle after the ack.
    wq.delete();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 1, 0, 32'h100 + 32'(4 * k), 32'(k), 15, 0, 0);
      #2 log_bus();
      check($sformatf("fill store%0d stall", k), {31'd0, stall_out}, 32'd0);
      @(negedge clk_in);
    end
    set_in(1, 1, 0, 32'h110, 32'h4, 15, 0, 0);
    #2 log_bus();
    check("fill 5th stall while full", {31'd0, stall_out}, 32'd1);
    check("fill head addr on bus", bus_addr_out, 32'h100);
    @(negedge clk_in);
    set_in(1, 1, 0, 32'h110, 32'h4, 15, 1, 0);
    #2 log_bus();
    check("fill 5th stall during pop", {31'd0, stall_out}, 32'd1);
    @(negedge clk_in);
    set_in(1, 1, 0, 32'h110, 32'h4, 15, 0, 0);
    #2 log_bus();
    check("fill 5th accepted after pop", {31'd0, stall_out}, 32'd0);
    @(negedge clk_in);
    drain("fill", 40);
    check_order("fill", 5, 32'h100);

    // Wrap-around: 10 stores with immediate acks; stall tracks a count model.
    wq.delete();
    cnt = 0;
    idx = 0;
    for (int c = 0; c < 100 && idx < 10; c++) begin
      set_in(1, 1, 0, 32'(4 * idx), 32'(idx), 15, 0, 0);
      #1 bus_ack_in = bus_req_out & bus_we_out;
      #1 log_bus();
      exp_stall = (cnt == 4);
      check($sformatf("wrap cyc%0d stall", c), {31'd0, stall_out}, {31'd0, exp_stall});
      if (!exp_stall) begin
        idx++;
        cnt++;
      end
      if (bus_ack_in) cnt--;
      @(negedge clk_in);
    end
    check("wrap all stores issued", idx, 10);
    drain("wrap", 40);
    check_order("wrap", 10, 32'h0);
    check("wrap final empty", {31'd0, buf_empty_out}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
